if_id_buffer: RTL and testbench

//  Parametrised IF/ID decoupling stage: a DEPTH-entry FIFO of {PCNext, instruction} pairs

---
 rtl/if_id_buffer_pkg.sv | 13 +
 rtl/if_id_fifo_mem.sv | 25 ++
 rtl/if_id_buffer.sv | 111 +++++++++++
 tb/tb_if_id_buffer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_buffer_pkg.sv
// Shared constants for the IF/ID decoupling buffer: field widths, NOP encoding and defaults.
package if_id_buffer_pkg;

    localparam int PC_BITS          = 32;
    localparam int INSTRUCTION_BITS = 32;

    // RISC-V canonical NOP (addi x0, x0, 0) shown to decode whenever the buffer is empty
    localparam logic [INSTRUCTION_BITS-1:0] NOP_INSTR = 32'h0000_0013;

    localparam int DEFAULT_DEPTH    = 2;
    localparam int DEFAULT_CNT_BITS = 16;

endpackage

// File: rtl/if_id_fifo_mem.sv
// DEPTH x WIDTH register file for the IF/ID buffer: one synchronous write port, one async read port.
module if_id_fifo_mem #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage is deliberately not reset; validity is tracked by the controller's count
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID decoupling FIFO with valid/ready handshakes, flush and NOP injection.
// Define IF_ID_PERF_CNT_EN to add saturating stall/flush performance counters.
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int                          PC_BITS_P  = PC_BITS,
    parameter int                          INSTR_BITS = INSTRUCTION_BITS,
    parameter int                          DEPTH      = DEFAULT_DEPTH,
    parameter logic [INSTRUCTION_BITS-1:0] NOP        = NOP_INSTR,
    parameter int                          CNT_BITS   = DEFAULT_CNT_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [PC_BITS_P-1:0]  i_PCNext,
    input  logic [INSTR_BITS-1:0] i_instruction,
    output logic                  o_valid,
    input  logic                  i_id_ready,
    output logic [PC_BITS_P-1:0]  o_PCNext,
    output logic [INSTR_BITS-1:0] o_instruction,
`ifdef IF_ID_PERF_CNT_EN
    output logic [CNT_BITS-1:0]   o_stall_cnt,
    output logic [CNT_BITS-1:0]   o_flush_cnt,
`endif
    input  logic                  i_flush
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WIDTH = PC_BITS_P + INSTR_BITS;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;
    logic [WIDTH-1:0] headData;

    // Handshake flags come from registered count only, so i_id_ready never reaches o_ready
    assign o_ready = (count_q < CNT_W'(DEPTH));
    assign o_valid = (count_q != '0);
    assign push    = i_valid & o_ready & ~i_flush;
    assign pop     = o_valid & i_id_ready & ~i_flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    if_id_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i ({i_PCNext, i_instruction}),
        .raddr_i (rd_ptr_q),
        .rdata_o (headData)
    );

    // Stale storage is masked so decode sees a harmless NOP at PC 0 when empty
    assign o_PCNext      = o_valid ? headData[WIDTH-1:INSTR_BITS] : '0;
    assign o_instruction = o_valid ? headData[INSTR_BITS-1:0]     : NOP;

`ifdef IF_ID_PERF_CNT_EN
    logic [CNT_BITS-1:0] stall_cnt_q;
    logic [CNT_BITS-1:0] flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (o_valid && !i_id_ready && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_BITS'(1);
            end
            if (i_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_BITS'(1);
            end
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed self-checking bench for if_id_buffer: instance A (DEPTH=2) and instance B (DEPTH=4, CNT_BITS=2).
module tb_if_id_buffer;
    import if_id_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;

    logic        aValid, aReady, aOValid, aIdReady, aFlush;
    logic [31:0] aPc, aInstr, aOPc, aOInstr;
    logic        bValid, bReady, bOValid, bIdReady, bFlush;
    logic [31:0] bPc, bInstr, bOPc, bOInstr;
`ifdef IF_ID_PERF_CNT_EN
    logic [15:0] aStallCnt, aFlushCnt;
    logic [1:0]  bStallCnt, bFlushCnt;
`endif

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    assign aInstr = 32'hA000_0000 | aPc;
    assign bInstr = 32'hB000_0000 | bPc;

    if_id_buffer #(.DEPTH(2), .CNT_BITS(16)) dutA (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (aValid),
        .o_ready       (aReady),
        .i_PCNext      (aPc),
        .i_instruction (aInstr),
        .o_valid       (aOValid),
        .i_id_ready    (aIdReady),
        .o_PCNext      (aOPc),
        .o_instruction (aOInstr),
`ifdef IF_ID_PERF_CNT_EN
        .o_stall_cnt   (aStallCnt),
        .o_flush_cnt   (aFlushCnt),
`endif
        .i_flush       (aFlush)
    );

    if_id_buffer #(.DEPTH(4), .CNT_BITS(2)) dutB (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (bValid),
        .o_ready       (bReady),
        .i_PCNext      (bPc),
        .i_instruction (bInstr),
        .o_valid       (bOValid),
        .i_id_ready    (bIdReady),
        .o_PCNext      (bOPc),
        .o_instruction (bOInstr),
`ifdef IF_ID_PERF_CNT_EN
        .o_stall_cnt   (bStallCnt),
        .o_flush_cnt   (bFlushCnt),
`endif
        .i_flush       (bFlush)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkHeadA(input string tag, input logic expValid, input logic expReady, input logic [31:0] expPc);
        checkOutput({tag, ".valid"}, {31'd0, aOValid}, {31'd0, expValid});
        checkOutput({tag, ".ready"}, {31'd0, aReady}, {31'd0, expReady});
        checkOutput({tag, ".pc"}, aOPc, expValid ? expPc : 32'd0);
        checkOutput({tag, ".instr"}, aOInstr, expValid ? (32'hA000_0000 | expPc) : NOP_INSTR);
    endtask

    task automatic checkHeadB(input string tag, input logic expValid, input logic expReady, input logic [31:0] expPc);
        checkOutput({tag, ".valid"}, {31'd0, bOValid}, {31'd0, expValid});
        checkOutput({tag, ".ready"}, {31'd0, bReady}, {31'd0, expReady});
        checkOutput({tag, ".pc"}, bOPc, expValid ? expPc : 32'd0);
        checkOutput({tag, ".instr"}, bOInstr, expValid ? (32'hB000_0000 | expPc) : NOP_INSTR);
    endtask

    // Drive instance A for one cycle, then settle just past the clock edge
    task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic idReady, input logic flush);
        aValid   = valid;
        aPc      = pc;
        aIdReady = idReady;
        aFlush   = flush;
        @(posedge clk);
        #1;
    endtask

    task automatic stepB();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic [31:0] expQ[$];
        int          modelCount;
        int          pushed;
        int          popped;
        logic        doPush;
        logic        doPop;

        rst = 1'b1;
        aValid = 1'b0; aPc = '0; aIdReady = 1'b0; aFlush = 1'b0;
        bValid = 1'b0; bPc = '0; bIdReady = 1'b0; bFlush = 1'b0;
        #12;
        checkHeadA("resetA", 1'b0, 1'b1, 32'd0);
        checkHeadB("resetB", 1'b0, 1'b1, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming: one entry in, one out each cycle
        applyStimulus(1'b1, 32'd4, 1'b1, 1'b0);
        checkHeadA("stream4", 1'b1, 1'b1, 32'd4);
        applyStimulus(1'b1, 32'd8, 1'b1, 1'b0);
        checkHeadA("stream8", 1'b1, 1'b1, 32'd8);
        applyStimulus(1'b1, 32'd12, 1'b1, 1'b0);
        checkHeadA("stream12", 1'b1, 1'b1, 32'd12);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkHeadA("streamDrain", 1'b0, 1'b1, 32'd0);

        // Stall until full, then release in order
        applyStimulus(1'b1, 32'h20, 1'b0, 1'b0);
        checkHeadA("stall1", 1'b1, 1'b1, 32'h20);
        applyStimulus(1'b1, 32'h24, 1'b0, 1'b0);
        checkHeadA("stallFull", 1'b1, 1'b0, 32'h20);
        applyStimulus(1'b0, 32'h24, 1'b0, 1'b0);
        checkHeadA("stallHold", 1'b1, 1'b0, 32'h20);
        applyStimulus(1'b0, 32'h24, 1'b1, 1'b0);
        checkHeadA("release24", 1'b1, 1'b1, 32'h24);
        applyStimulus(1'b0, 32'h24, 1'b1, 1'b0);
        checkHeadA("releaseEmpty", 1'b0, 1'b1, 32'd0);

        // Full with simultaneous pop: push must wait one cycle
        applyStimulus(1'b1, 32'h30, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h34, 1'b0, 1'b0);
        checkHeadA("bubbleFull", 1'b1, 1'b0, 32'h30);
        applyStimulus(1'b1, 32'h38, 1'b1, 1'b0);
        checkHeadA("bubblePopOnly", 1'b1, 1'b1, 32'h34);
        applyStimulus(1'b1, 32'h38, 1'b1, 1'b0);
        checkHeadA("bubblePush38", 1'b1, 1'b1, 32'h38);
        applyStimulus(1'b0, 32'h38, 1'b1, 1'b0);
        checkHeadA("bubbleEmpty", 1'b0, 1'b1, 32'd0);

        // Flush with two entries and a pending fetch
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h44, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h48, 1'b1, 1'b1);
        checkHeadA("flushA", 1'b0, 1'b1, 32'd0);
        applyStimulus(1'b1, 32'h50, 1'b0, 1'b0);
        checkHeadA("postFlushA", 1'b1, 1'b1, 32'h50);
        applyStimulus(1'b0, 32'h50, 1'b0, 1'b1);
        checkHeadA("flushA2", 1'b0, 1'b1, 32'd0);

        // Asynchronous reset mid-stream with two entries
        applyStimulus(1'b1, 32'h60, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h64, 1'b0, 1'b0);
        checkHeadA("preReset", 1'b1, 1'b0, 32'h60);
        aValid = 1'b0;
        rst = 1'b1;
        #1;
        checkHeadA("midReset", 1'b0, 1'b1, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkHeadA("afterReset", 1'b0, 1'b1, 32'd0);

        // Flush on B where a push would otherwise be accepted
        bIdReady = 1'b0; bValid = 1'b1; bPc = 32'h200;
        stepB();
        bPc = 32'h204;
        stepB();
        checkHeadB("bTwo", 1'b1, 1'b1, 32'h200);
        bPc = 32'h208; bFlush = 1'b1;
        stepB();
        checkHeadB("bFlush", 1'b0, 1'b1, 32'd0);
        bFlush = 1'b0;
        stepB();
        checkHeadB("bPostFlush", 1'b1, 1'b1, 32'h208);
        bValid = 1'b0; bIdReady = 1'b1;
        stepB();
        checkHeadB("bEmpty", 1'b0, 1'b1, 32'd0);

        // Pointer wrap on B with random decode readiness against a scoreboard
        modelCount = 0;
        pushed = 0;
        popped = 0;
        for (int cyc = 0; cyc < 200 && popped < 10; cyc++) begin
            bValid   = (pushed < 10);
            bPc      = 32'h100 + 32'(4 * pushed);
            bIdReady = (cyc >= 120) ? 1'b1 : 1'($urandom_range(0, 1));
            doPush   = bValid && (modelCount < 4);
            doPop    = (modelCount != 0) && bIdReady;
            checkOutput("wrapReady", {31'd0, bReady}, {31'd0, modelCount < 4});
            if (modelCount != 0) checkOutput("wrapHead", bOPc, expQ[0]);
            stepB();
            if (doPush) begin
                expQ.push_back(32'h100 + 32'(4 * pushed));
                pushed++;
            end
            if (doPop) begin
                void'(expQ.pop_front());
                popped++;
            end
            modelCount = expQ.size();
        end
        bValid = 1'b0;
        checkOutput("wrapDrained", 32'(popped), 32'd10);
        checkHeadB("wrapEmpty", 1'b0, 1'b1, 32'd0);

`ifdef IF_ID_PERF_CNT_EN
        rst = 1'b1;
        #1;
        rst = 1'b0;
        checkOutput("aStallReset", {16'd0, aStallCnt}, 32'd0);
        checkOutput("aFlushReset", {16'd0, aFlushCnt}, 32'd0);
        checkOutput("bStallReset", {30'd0, bStallCnt}, 32'd0);
        checkOutput("bFlushReset", {30'd0, bFlushCnt}, 32'd0);
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h300, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h300, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h300, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h300, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h300, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h300, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h300, 1'b1, 1'b0);
        checkOutput("aStallCnt", {16'd0, aStallCnt}, 32'd3);
        checkOutput("aFlushCnt", {16'd0, aFlushCnt}, 32'd2);

        bValid = 1'b1; bIdReady = 1'b0; bPc = 32'h400;
        stepB();
        bValid = 1'b0;
        stepB();
        stepB();
        checkOutput("bStallTwo", {30'd0, bStallCnt}, 32'd2);
        stepB();
        stepB();
        stepB();
        checkOutput("bStallSat", {30'd0, bStallCnt}, 32'd3);
        bIdReady = 1'b1; bFlush = 1'b1;
        for (int i = 0; i < 4; i++) stepB();
        bFlush = 1'b0;
        stepB();
        checkOutput("bFlushSat", {30'd0, bFlushCnt}, 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
